rbm_hidden_sampler: RTL

//  Downstream of the forward GEMV/sigmoid core. Accepts one hidden probability p_j
//  (Q0.16) per handshake and draws a Bernoulli sample h_j against an internal LFSR.

---
 rtl/rbm_hidden_sampler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rbm_hidden_sampler.sv
// rbm_hidden_sampler
//   Takes one hidden-unit probability p_j (Q0.16 unsigned) per handshake from the
//   GEMV/sigmoid core. It draws a Bernoulli sample h_j against a 32-bit Galois LFSR.
//   It stores p_j and h_j for the H_DIM hiddens of one frame, and the CD stage
//   reads them back through a registered read port.
//
// Optional feature: define RBM_SAMPLER_MEANFIELD_EN to add the mean_field input.
//   With mean_field=1, h = p_in[15]. The LFSR still advances in this mode.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   start            begin a frame (sampled only in IDLE)
//   busy             high while collecting
//   in_valid/ready   probability handshake; in_ready is high only in COLLECT
//   p_in             hidden probability, Q0.16
//   mean_field       (optional) deterministic threshold select
//   done             one-cycle pulse after the last accept of a frame
//   ones_cnt         number of h==1 in the current/last frame
//   rd_addr          read index
//   rd_p, rd_h       stored p/h at rd_addr, one cycle latency
module rbm_hidden_sampler #(
  parameter int          H_DIM     = 64,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468,
  localparam int         CW        = $clog2(H_DIM + 1),
  localparam int         AW        = $clog2(H_DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   p_in,
`ifdef RBM_SAMPLER_MEANFIELD_EN
  input  logic          mean_field,
`endif
  output logic          done,
  output logic [CW-1:0] ones_cnt,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_p,
  output logic          rd_h
);

  localparam logic [31:0]   LFSR_MASK = 32'h80200003;
  localparam logic [AW-1:0] IDX_LAST  = AW'(H_DIM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} st_t;

  st_t           st, st_nxt;
  logic [AW-1:0] idx;
  logic [31:0]   lfsr;
  logic          accept;
  logic          h_stoch;
  logic          h;

  logic [15:0]   p_mem [H_DIM];
  logic          h_mem [H_DIM];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic and FSM outputs.
  always_comb begin
    st_nxt   = st;
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    case (st)
      IDLE:    if (start) st_nxt = COLLECT;
      COLLECT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && idx == IDX_LAST) st_nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Compare against the LFSR value before it advances on this accept.
  assign h_stoch = (p_in > lfsr[15:0]);
`ifdef RBM_SAMPLER_MEANFIELD_EN
  assign h = mean_field ? p_in[15] : h_stoch;
`else
  assign h = h_stoch;
`endif

  // Frame datapath: index, ones counter, LFSR.
  // The LFSR runs freely across frames. A start does not reseed it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      ones_cnt <= '0;
      lfsr     <= LFSR_SEED;
    end else if (st == IDLE && start) begin
      idx      <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      ones_cnt <= ones_cnt + CW'(h);
      lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
      if (idx != IDX_LAST) idx <= idx + 1'b1;
    end
  end

  // Storage is not reset. Its contents are valid only after a frame writes them.
  always_ff @(posedge clk) begin
    if (accept) begin
      p_mem[idx] <= p_in;
      h_mem[idx] <= h;
    end
  end

  // Registered read. A read of an entry written in the same cycle returns the old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_p <= '0;
      rd_h <= 1'b0;
    end else begin
      rd_p <= p_mem[rd_addr];
      rd_h <= h_mem[rd_addr];
    end
  end

endmodule
